ask_symbol_detector: RTL and testbench

//  Downstream receive-side stage for the ASK modulator output (8-bit attenuated DAC samples).
//  Per symbol window: measures the carrier peak and slices it to a 2/4/8-level symbol.
//  Re-serialises each symbol MSB-first into bits, in the order the modulator consumed them.

---
 rtl/ask_symbol_detector.sv | 164 ++++++++++++++++
 tb/tb_ask_symbol_detector.sv | 139 +++++++++++++
 2 files changed

// File: rtl/ask_symbol_detector.sv
// ask_symbol_detector
//   Purpose: receive-side ASK slicer. Each symbol window it tracks the carrier
//            peak, slices it to a 2/4/8-level symbol and re-serialises that
//            symbol MSB-first so it lines up with the modulator's bit source.
//   Ports:   clk, rst (sync, active-high); mixer_mode_i-style inputs mixer_mode,
//            sample_in, sync_in; outputs locked, sym_out/sym_valid (one pulse
//            per decided symbol), bit_out/bit_valid (k pulses after sym_valid).
//   Timing:  window end at cnt==T-1 -> sym_valid next cycle -> bits in the k
//            cycles after that. No backpressure; outputs are pulses.
module ask_symbol_detector #(
  parameter int DATA_WIDTH    = 8,
  parameter int SYMBOL_CYCLES = 5000,
  parameter int SETTLE_CYCLES = 200,   // must be >= 2 and < SYMBOL_CYCLES
  parameter int FULL_PEAK     = 204
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mixer_mode,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sync_in,
  output logic                  locked,
  output logic [2:0]            sym_out,
  output logic                  sym_valid,
  output logic                  bit_out,
  output logic                  bit_valid
);

  localparam int CW = $clog2(3 * SYMBOL_CYCLES + 1);
  localparam int PW = DATA_WIDTH + 6;   // holds 2*7*max_sample and 13*FULL_PEAK

  typedef logic [CW-1:0] cnt_t;
  typedef logic [PW-1:0] prod_t;
  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE} state_t;

  localparam cnt_t LAST_K1     = cnt_t'(SYMBOL_CYCLES - 1);
  localparam cnt_t LAST_K2     = cnt_t'(2 * SYMBOL_CYCLES - 1);
  localparam cnt_t LAST_K3     = cnt_t'(3 * SYMBOL_CYCLES - 1);
  localparam cnt_t SETTLE_LAST = cnt_t'(SETTLE_CYCLES - 1);

  state_t                  state_q;
  cnt_t                    cnt_q;
  logic [DATA_WIDTH-1:0]   peak_q;
  logic [1:0]              mode_q;
  logic [2:0]              sym_q;
  logic                    sym_valid_q;
  logic [2:0]              ser_sh_q;    // symbol left-aligned, next bit at [2]
  logic [1:0]              ser_left_q;  // bits still to emit
  logic                    bit_q;
  logic                    bit_valid_q;

  // Per-mode window length and level count (k == mixer_mode numerically)
  cnt_t                    cnt_last;
  logic [2:0]              lm1;
  logic [DATA_WIDTH-1:0]   peak_now;
  prod_t                   lhs;
  logic [2:0]              sym_d;
  logic [2:0]              ser_load;
  logic                    abort;

  always_comb begin
    cnt_last = LAST_K1;
    lm1      = 3'd1;
    ser_load = 3'd0;
    case (mixer_mode)
      2'b10:   begin cnt_last = LAST_K2; lm1 = 3'd3; end
      2'b11:   begin cnt_last = LAST_K3; lm1 = 3'd7; end
      default: begin cnt_last = LAST_K1; lm1 = 3'd1; end
    endcase

    // Decision includes the sample arriving on the window-end cycle
    peak_now = (sample_in > peak_q) ? sample_in : peak_q;

    // Threshold j sits midway between levels j-1 and j:
    //   P/FULL >= (2j-1)/(2(L-1))  <=>  2(L-1)P >= (2j-1)FULL
    lhs   = prod_t'(peak_now) * prod_t'({lm1, 1'b0});
    sym_d = 3'd0;
    for (int j = 1; j <= 7; j++) begin
      if (3'(j) <= lm1 && lhs >= prod_t'((2 * j - 1) * FULL_PEAK))
        sym_d = sym_d + 3'd1;
    end

    case (mixer_mode)
      2'b01:   ser_load = {sym_d[0], 2'b00};
      2'b10:   ser_load = {sym_d[1:0], 1'b0};
      default: ser_load = sym_d;
    endcase

    abort = (mixer_mode == 2'b00) || (mixer_mode != mode_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      peak_q      <= '0;
      mode_q      <= 2'b00;
      sym_q       <= 3'd0;
      sym_valid_q <= 1'b0;
      ser_sh_q    <= 3'd0;
      ser_left_q  <= 2'd0;
      bit_q       <= 1'b0;
      bit_valid_q <= 1'b0;
    end else begin
      mode_q      <= mixer_mode;
      sym_valid_q <= 1'b0;

      // Serializer runs independently of the FSM so an abort cannot cut a burst
      if (ser_left_q != 2'd0) begin
        bit_q       <= ser_sh_q[2];
        bit_valid_q <= 1'b1;
        ser_sh_q    <= {ser_sh_q[1:0], 1'b0};
        ser_left_q  <= ser_left_q - 2'd1;
      end else begin
        bit_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          // Sync cycle is window index 0, so the next cycle is index 1
          if (sync_in && mixer_mode != 2'b00) begin
            state_q <= SETTLE;
            cnt_q   <= cnt_t'(1);
            peak_q  <= '0;
          end
        end
        default: begin
          if (abort) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            peak_q  <= '0;
          end else if (sync_in) begin
            // Resync beats a coincident window end: partial window dropped
            state_q <= SETTLE;
            cnt_q   <= cnt_t'(1);
            peak_q  <= '0;
          end else if (cnt_q == cnt_last) begin
            state_q     <= SETTLE;
            cnt_q       <= '0;
            peak_q      <= '0;
            sym_q       <= sym_d;
            sym_valid_q <= 1'b1;
            ser_sh_q    <= ser_load;
            ser_left_q  <= mixer_mode;
          end else begin
            cnt_q <= cnt_q + cnt_t'(1);
            if (state_q == SETTLE) begin
              if (cnt_q == SETTLE_LAST)
                state_q <= MEASURE;
            end else begin
              peak_q <= peak_now;
            end
          end
        end
      endcase
    end
  end

  assign locked    = (state_q != IDLE);
  assign sym_out   = sym_q;
  assign sym_valid = sym_valid_q;
  assign bit_out   = bit_q;
  assign bit_valid = bit_valid_q;

endmodule

// File: tb/tb_ask_symbol_detector.sv
// tb_ask_symbol_detector
//   Directed scenarios on a shortened symbol (20 cycles, 4 settle, full peak 200).
//   Cycle c of a scenario: outputs observed at the negedge inside cycle c,
//   then inputs for cycle c are driven; the sync pulse is cycle 0.
module tb_ask_symbol_detector;

  localparam int SC = 20;
  localparam int ST = 4;
  localparam int FP = 200;
  localparam int NEVER = 100000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mixer_mode = 2'b00;
  logic [7:0] sample_in = 8'd0;
  logic       sync_in = 1'b0;
  logic       locked;
  logic [2:0] sym_out;
  logic       sym_valid;
  logic       bit_out;
  logic       bit_valid;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ask_symbol_detector #(
    .DATA_WIDTH    (8),
    .SYMBOL_CYCLES (SC),
    .SETTLE_CYCLES (ST),
    .FULL_PEAK     (FP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mixer_mode (mixer_mode),
    .sample_in  (sample_in),
    .sync_in    (sync_in),
    .locked     (locked),
    .sym_out    (sym_out),
    .sym_valid  (sym_valid),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid)
  );

  task automatic check_eq(input string tag, input int cyc, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [7:0] samp(input int id, input int c);
    case (id)
      0: return (c == 10) ? 8'd200 : (c == 39) ? 8'd50 : 8'd20;
      1: return (c == 39) ? 8'd133 : 8'd30;
      2: return (c == 30) ? 8'd114 : (c == 100) ? 8'd255 : 8'd5;
      3: return (c < 4) ? 8'd250 : 8'd10;
      4: return (c == 20) ? 8'd255 : (c == 50) ? 8'd114 : 8'd5;
      5: return (c == 20) ? 8'd200 : 8'd5;
      default: return (c == 10) ? 8'd255 : 8'd5;
    endcase
  endfunction

  // Idle a few cycles with mode off so every scenario starts from IDLE
  task automatic gap();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst = 1'b0; mixer_mode = 2'b00; sync_in = 1'b0; sample_in = 8'd0;
    end
  endtask

  task automatic run_scen(input int id, input logic [1:0] mode, input int ncyc,
                          input int sv0, input logic [2:0] sym0,
                          input int sv1, input logic [2:0] sym1,
                          input int resync_c, input int abort_c, input int rst_c);
    int k;
    logic esv, ebv, eb, elk;
    logic [2:0] esym, s;
    logic [1:0] idx;
    k = int'(mode);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      esv = 1'b0; ebv = 1'b0; eb = 1'b0; esym = 3'd0; s = 3'd0; idx = 2'd0;
      if (c == sv0) begin esv = 1'b1; esym = sym0; end
      if (c == sv1) begin esv = 1'b1; esym = sym1; end
      if (sv0 >= 0 && c > sv0 && c <= sv0 + k) begin
        ebv = 1'b1; s = sym0; idx = 2'(k - 1 - (c - sv0 - 1)); eb = s[idx];
      end
      if (sv1 >= 0 && c > sv1 && c <= sv1 + k) begin
        ebv = 1'b1; s = sym1; idx = 2'(k - 1 - (c - sv1 - 1)); eb = s[idx];
      end
      elk = (c >= 1 && c <= abort_c && c <= rst_c);
      if (c > rst_c) begin
        esv = 1'b0; ebv = 1'b0; eb = 1'b0; esym = 3'd0;
      end
      check_eq("sym_valid", c, {7'd0, sym_valid}, {7'd0, esv});
      check_eq("bit_valid", c, {7'd0, bit_valid}, {7'd0, ebv});
      check_eq("locked",    c, {7'd0, locked},    {7'd0, elk});
      if (esv || c > rst_c) check_eq("sym_out", c, {5'd0, sym_out}, {5'd0, esym});
      if (ebv || c > rst_c) check_eq("bit_out", c, {7'd0, bit_out}, {7'd0, eb});
      rst        = (c >= rst_c);
      mixer_mode = (c >= abort_c) ? 2'b00 : mode;
      sync_in    = (c == 0 || c == resync_c);
      sample_in  = samp(id, c);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_locked",    0, {7'd0, locked},    8'd0);
    check_eq("rst_sym_out",   0, {5'd0, sym_out},   8'd0);
    check_eq("rst_sym_valid", 0, {7'd0, sym_valid}, 8'd0);
    check_eq("rst_bit_out",   0, {7'd0, bit_out},   8'd0);
    check_eq("rst_bit_valid", 0, {7'd0, bit_valid}, 8'd0);

    // 2ASK: peak 200 -> 1, then peak 50 arriving on the window-end cycle -> 0
    gap(); run_scen(0, 2'b01, 45, 20, 3'd1, 40, 3'd0, -1, NEVER, NEVER);
    // 4ASK: peak 133 on the last cycle -> 2, bits 1,0
    gap(); run_scen(1, 2'b10, 45, 40, 3'd2, -1, 3'd0, -1, NEVER, NEVER);
    // 8ASK: 114 -> 4, then 255 saturates at 7
    gap(); run_scen(2, 2'b11, 125, 60, 3'd4, 120, 3'd7, -1, NEVER, NEVER);
    // 8ASK: large samples only during settle are ignored -> 0
    gap(); run_scen(3, 2'b11, 65, 60, 3'd0, -1, 3'd0, -1, NEVER, NEVER);
    // 8ASK: resync at 30 drops the partial window; decision at 90 -> 4
    gap(); run_scen(4, 2'b11, 95, 90, 3'd4, -1, 3'd0, 30, NEVER, NEVER);
    // 8ASK: mode to 00 at 30 -> unlocked at 31, no decision
    gap(); run_scen(5, 2'b11, 70, -1, 3'd0, -1, 3'd0, -1, 30, NEVER);
    // 8ASK: reset asserted in cycle 62 during the 7 burst
    gap(); run_scen(6, 2'b11, 66, 60, 3'd7, -1, 3'd0, -1, NEVER, 62);
    gap();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
